// File: rtl/in_port_pkg.sv
// Shared constants and types for the in_port_array input-port block.
package in_port_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_NUM_CH = 4;

  // Which source a read selects.
  typedef enum logic [1:0] {
    RD_CHAN   = 2'd0,
    RD_STATUS = 2'd1,
    RD_NONE   = 2'd2
  } rdKind_t;

  // The status word sits directly after the last channel.
  function automatic int statusOfs(input int numCh);
    return numCh;
  endfunction

endpackage

// File: rtl/in_port_sync.sv
// One input channel: optional synchroniser (IN_PORT_SYNC_EN), cur/prev
// registers and a sticky change flag where a new change beats a clear.
module in_port_sync
  import in_port_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic [DATA_W-1:0] cur,
  output logic              chg
);

  logic [DATA_W-1:0] curR;
  logic [DATA_W-1:0] prevR;
  logic              chgR;
`ifdef IN_PORT_SYNC_EN
  logic [DATA_W-1:0] syncR;
`endif

  // Channel state: capture input, age cur into prev, track the sticky change flag.
  always_ff @(posedge clk) begin
    if (Reset) begin
`ifdef IN_PORT_SYNC_EN
      syncR <= {DATA_W{1'b0}};
`endif
      curR  <= {DATA_W{1'b0}};
      prevR <= {DATA_W{1'b0}};
      chgR  <= 1'b0;
    end else begin
`ifdef IN_PORT_SYNC_EN
      // curR doubles as the second synchroniser stage.
      syncR <= din;
      curR  <= syncR;
`else
      curR  <= din;
`endif
      prevR <= curR;
      chgR  <= (curR != prevR) | (chgR & ~clr);
    end
  end

  assign cur = curR;
  assign chg = chgR;

endmodule

// File: rtl/in_port_array.sv
// Memory-mapped array of NUM_CH input ports with sticky change flags, a status
// word and a masked change interrupt. Build option: IN_PORT_SYNC_EN.
module in_port_array
  import in_port_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter int                NUM_CH    = DEFAULT_NUM_CH,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     INportRead,
  input  logic [ADDR_W-1:0]        Address,
  input  logic [NUM_CH*DATA_W-1:0] InpExtWorld,
  input  logic [NUM_CH-1:0]        IrqMask,
  output logic [DATA_W-1:0]        Dataout,
  output logic                     DataValid,
  output logic                     ChangeIrq
);

  localparam int STATUS_OFS = statusOfs(NUM_CH);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(int'(BASE_ADDR) + STATUS_OFS);

  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : gBadNumCh
    $error("in_port_array: NUM_CH must be in 1..16");
  end
  if ((int'(BASE_ADDR) + STATUS_OFS) > ((2 ** ADDR_W) - 1)) begin : gBadAddr
    $error("in_port_array: BASE_ADDR+NUM_CH wraps the address space");
  end

  logic [DATA_W-1:0] curAll [NUM_CH];
  logic [NUM_CH-1:0] chgVec;
  logic [NUM_CH-1:0] clrVec;
  logic [NUM_CH-1:0] hitVec;
  logic [DATA_W-1:0] chanData;
  logic [DATA_W-1:0] statusWord;
  rdKind_t           rdKind;

  logic [DATA_W-1:0] dataoutR;
  logic              dataValidR;
  logic              changeIrqR;

  for (genvar k = 0; k < NUM_CH; k++) begin : gCh
    in_port_sync #(.DATA_W(DATA_W)) uSync (
      .clk  (clk),
      .Reset(Reset),
      .din  (InpExtWorld[k*DATA_W +: DATA_W]),
      .clr  (clrVec[k]),
      .cur  (curAll[k]),
      .chg  (chgVec[k])
    );
  end

  // Address decode: channel hits, flag clears, selected data and status word.
  always_comb begin
    hitVec     = {NUM_CH{1'b0}};
    clrVec     = {NUM_CH{1'b0}};
    chanData   = {DATA_W{1'b0}};
    statusWord = DATA_W'(chgVec);
    for (int k = 0; k < NUM_CH; k++) begin
      hitVec[k] = (Address == ADDR_W'(int'(BASE_ADDR) + k));
      clrVec[k] = INportRead & hitVec[k] & ~Reset;
      chanData  = chanData | (hitVec[k] ? curAll[k] : {DATA_W{1'b0}});
    end
    if (|hitVec) begin
      rdKind = RD_CHAN;
    end else if (Address == STATUS_ADDR) begin
      rdKind = RD_STATUS;
    end else begin
      rdKind = RD_NONE;
    end
  end

  // Registered read port and interrupt output.
  always_ff @(posedge clk) begin
    if (Reset) begin
      dataoutR   <= {DATA_W{1'b0}};
      dataValidR <= 1'b0;
      changeIrqR <= 1'b0;
    end else begin
      dataValidR <= INportRead;
      changeIrqR <= |(chgVec & IrqMask);
      if (INportRead) begin
        case (rdKind)
          RD_CHAN:   dataoutR <= chanData;
          RD_STATUS: dataoutR <= statusWord;
          default:   dataoutR <= {DATA_W{1'b0}};
        endcase
      end else begin
        dataoutR <= dataoutR;
      end
    end
  end

  assign Dataout   = dataoutR;
  assign DataValid = dataValidR;
  assign ChangeIrq = changeIrqR;

endmodule

// File: tb/tb_in_port_array.sv
// Directed, table-driven bench for in_port_array with default parameters.
module tb_in_port_array;

`ifdef IN_PORT_SYNC_EN
  localparam int CHG_LAT = 3;
`else
  localparam int CHG_LAT = 2;
`endif

  logic        clk;
  logic        Reset;
  logic        INportRead;
  logic [7:0]  Address;
  logic [31:0] InpExtWorld;
  logic [3:0]  IrqMask;
  logic [7:0]  Dataout;
  logic        DataValid;
  logic        ChangeIrq;

  int total;
  int bad;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs [10];

  in_port_array dut (
    .clk        (clk),
    .Reset      (Reset),
    .INportRead (INportRead),
    .Address    (Address),
    .InpExtWorld(InpExtWorld),
    .IrqMask    (IrqMask),
    .Dataout    (Dataout),
    .DataValid  (DataValid),
    .ChangeIrq  (ChangeIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle read; outputs are visible on return.
  task automatic doRead(input logic [7:0] addr);
    INportRead = 1'b1;
    Address    = addr;
    tick();
    INportRead = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{8'h04, 8'h09};
    vecs[1] = '{8'h7F, 8'h00};
    vecs[2] = '{8'h04, 8'h09};
    vecs[3] = '{8'h00, 8'h11};
    vecs[4] = '{8'h01, 8'h3D};
    vecs[5] = '{8'h02, 8'hA5};
    vecs[6] = '{8'h03, 8'hF0};
    vecs[7] = '{8'h04, 8'h00};
    vecs[8] = '{8'h05, 8'h00};
    vecs[9] = '{8'hFF, 8'h00};

    Reset       = 1'b1;
    INportRead  = 1'b0;
    Address     = 8'h00;
    InpExtWorld = 32'h0;
    IrqMask     = 4'h0;
    tick();
    tick();
    check("reset_dataout", Dataout, 8'h00);
    check("reset_valid", DataValid, 1'b0);
    check("reset_irq", ChangeIrq, 1'b0);

    // Channel 2 read clears its flag.
    Reset       = 1'b0;
    InpExtWorld = 32'h00A5_0000;
    repeat (4) tick();
    doRead(8'h04);
    check("ch2_status_set", Dataout, 8'h04);
    doRead(8'h02);
    check("ch2_data", Dataout, 8'hA5);
    check("ch2_valid", DataValid, 1'b1);
    tick();
    check("ch2_valid_pulse", DataValid, 1'b0);
    check("ch2_hold", Dataout, 8'hA5);
    doRead(8'h04);
    check("ch2_status_clr", Dataout, 8'h00);

    // Change on ch1 with mask enabled: interrupt one cycle after the flag.
    IrqMask     = 4'b0010;
    InpExtWorld = 32'h00A5_3C00;
    repeat (CHG_LAT) tick();
    check("irq_not_early", ChangeIrq, 1'b0);
    tick();
    check("irq_set", ChangeIrq, 1'b1);
    doRead(8'h04);
    check("ch1_status", Dataout, 8'h02);
    check("irq_hold", ChangeIrq, 1'b1);

    // Read ch1 on the very edge a new change sets its flag: set wins.
    InpExtWorld = 32'h00A5_3D00;
    repeat (CHG_LAT - 1) tick();
    doRead(8'h01);
    check("setwin_data", Dataout, 8'h3D);
    doRead(8'h04);
    check("setwin_status", Dataout, 8'h02);
    doRead(8'h01);
    doRead(8'h04);
    check("ch1_cleared", Dataout, 8'h00);
    check("irq_cleared", ChangeIrq, 1'b0);

    // Back-to-back read table.
    InpExtWorld = 32'hF0A5_3D11;
    repeat (4) tick();
    INportRead = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Address = vecs[i].addr;
      tick();
      check($sformatf("vec%0d_data", i), Dataout, vecs[i].expData);
      check($sformatf("vec%0d_valid", i), DataValid, 1'b1);
    end
    INportRead = 1'b0;
    tick();
    check("table_valid_low", DataValid, 1'b0);

    // Reset during a read with every flag set.
    IrqMask     = 4'hF;
    InpExtWorld = 32'h0403_0201;
    repeat (4) tick();
    doRead(8'h04);
    check("all_flags", Dataout, 8'h0F);
    check("all_irq", ChangeIrq, 1'b1);
    Reset      = 1'b1;
    INportRead = 1'b1;
    Address    = 8'h00;
    tick();
    check("rst_rd_dataout", Dataout, 8'h00);
    check("rst_rd_valid", DataValid, 1'b0);
    check("rst_rd_irq", ChangeIrq, 1'b0);
    Reset = 1'b0;
    doRead(8'h04);
    check("post_rst_no_flag", Dataout, 8'h00);
    repeat (4) tick();
    doRead(8'h04);
    check("post_rst_flags", Dataout, 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/in_port_array.md
IN_PORT_ARRAY -- requirements
Module: in_port_array

Interface
REQ-001 Parameter DATA_W, default 8: width of each input channel and of Dataout.
REQ-002 Parameter NUM_CH, default 4, range 1..16: number of external input channels.
REQ-003 Parameter ADDR_W, default 8: width of Address.
REQ-004 Parameter BASE_ADDR, default 8'h00: address of channel 0.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 INportRead  in  1  read strobe, one-cycle request per read.
REQ-008 Address  in  ADDR_W  port select for the current read.
REQ-009 InpExtWorld  in  NUM_CH*DATA_W  flattened external inputs; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 IrqMask  in  NUM_CH  per-channel change-interrupt enable.
REQ-011 Dataout  out  DATA_W  registered read data.
REQ-012 DataValid  out  1  one-cycle pulse marking Dataout updated by a read.
REQ-013 ChangeIrq  out  1  registered OR of (change flags AND IrqMask).

Function
REQ-014 Each channel SHALL keep a current value cur[k] and a previous value prev[k]; prev[k] <= cur[k] every cycle.
REQ-015 chg[k] (sticky) SHALL be set on the edge where cur[k] != prev[k].
REQ-016 Address BASE_ADDR+k, k < NUM_CH, SHALL select cur[k]; a read of it SHALL clear chg[k].
REQ-017 Address BASE_ADDR+NUM_CH SHALL select the status word {zero-extend, chg[NUM_CH-1:0]}, truncated to DATA_W; a status read SHALL NOT clear flags.
REQ-018 Any other address SHALL return 0 and SHALL clear no flags.
REQ-019 Read latency: INportRead sampled high at edge N SHALL update Dataout and pulse DataValid at edge N; both are visible in cycle N+1.
REQ-020 DataValid SHALL be low on every cycle with no read; Dataout SHALL hold its last value between reads.
REQ-021 Back-to-back reads SHALL each be serviced, one per cycle, with no stall.
REQ-022 Simultaneous clear (read of channel k) and new change on k at the same edge: set SHALL win; chg[k] stays 1.
REQ-023 ChangeIrq SHALL be registered: it reflects the flag/mask state of the previous edge, one cycle behind chg.
REQ-024 Address arithmetic SHALL be an ADDR_W-bit unsigned compare; BASE_ADDR+NUM_CH SHALL not wrap within ADDR_W (elaboration check).

Reset
REQ-025 When Reset is high at an edge: Dataout=0, DataValid=0, ChangeIrq=0, all chg=0, all cur/prev/sync stages=0.
REQ-026 Reset SHALL dominate INportRead; a read coincident with Reset SHALL be dropped.
REQ-027 The first cycle after Reset SHALL NOT flag a change unless the input differs from 0 after synchronisation.

Configuration
REQ-028 Macro IN_PORT_SYNC_EN defined: each input bit SHALL pass through a 2-flop synchroniser before cur[k]; an input change before edge E appears in cur at E+1 and in chg at E+2.
REQ-029 Macro IN_PORT_SYNC_EN undefined: cur[k] SHALL register the input directly; the change appears in cur at E and in chg at E+1.

Structure
REQ-030 Package in_port_pkg SHALL hold the status-offset constant (STATUS_OFS = NUM_CH relation) and the default DATA_W/NUM_CH values.
REQ-031 Sub-module in_port_sync (one channel: synchroniser or bypass, cur/prev, chg set/clear) SHALL be instantiated NUM_CH times in a generate loop.

Verification
REQ-032 Reset, InpExtWorld ch2=8'hA5 settled, read Address 8'h02 -> Dataout=8'hA5, DataValid one cycle, chg[2] cleared.
REQ-033 Change ch1 from 8'h00 to 8'h3C, IrqMask=4'b0010 -> chg[1] set at required latency (REQ-028/029), ChangeIrq=1 one cycle later; status read (8'h04) -> 8'h02, ChangeIrq stays 1.
REQ-034 Read ch1 in the same cycle ch1 changes again to 8'h3D -> chg[1] stays 1 (set wins).
REQ-035 Reads to 8'h00,8'h01,8'h02,8'h03 on consecutive cycles -> four DataValid pulses, data in order, no gaps.
REQ-036 Read Address 8'h7F -> Dataout=8'h00, DataValid=1, flags unchanged.
REQ-037 Assert Reset during a read with chg=4'hF -> Dataout=0, DataValid=0, chg=0, ChangeIrq=0 next cycle.
